// File: rtl/swc_page_alloc_core.sv
// Page allocator core: free-page FIFO plus per-page use count / allocated bit,
// serving one alloc / free / force_free / set_usecnt request at a time.
module swc_page_alloc_core #(
  parameter int g_num_pages       = 1024,
  parameter int g_page_addr_width = 10,
  parameter int g_usecnt_width    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         alloc_i,
  input  logic                         free_i,
  input  logic                         force_free_i,
  input  logic                         set_usecnt_i,
  input  logic [g_usecnt_width-1:0]    usecnt_i,
  input  logic [g_page_addr_width-1:0] pgaddr_free_i,
  input  logic [g_page_addr_width-1:0] pgaddr_force_free_i,
  input  logic [g_page_addr_width-1:0] pgaddr_usecnt_i,
  output logic [g_page_addr_width-1:0] pgaddr_alloc_o,
  output logic                         done_o,
  output logic                         alloc_done_o,
  output logic                         free_done_o,
  output logic                         force_free_done_o,
  output logic                         set_usecnt_done_o,
  output logic                         free_last_usecnt_o,
  output logic                         nomem_o,
  output logic                         err_o,
  output logic [g_page_addr_width:0]   free_pages_o
);

  localparam int AW = g_page_addr_width;
  localparam int UW = g_usecnt_width;
  localparam int CW = g_page_addr_width + 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ALLOC, OP_FREE, OP_FFREE, OP_SETUC} op_t;

  typedef struct packed {
    op_t           op;
    logic [AW-1:0] page;
    logic [UW-1:0] usecnt;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q, req_nxt;
  logic   sel_valid;

  logic [AW-1:0] fifo_mem  [g_num_pages];
  logic [UW-1:0] use_mem   [g_num_pages];
  logic          alloc_mem [g_num_pages];

  logic [AW-1:0] rd_ptr, wr_ptr, init_cnt;
  logic [CW-1:0] count;
  logic          init_last;

  logic [AW-1:0] head;
  logic [UW-1:0] cur_use;
  logic          cur_alloc;

  logic          do_pop, do_push, release_pg, op_err, op_last;
  logic          use_we, al_we, fifo_we, al_wd;
  logic [AW-1:0] use_wa, al_wa, fifo_wa, fifo_wd;
  logic [UW-1:0] use_wd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(g_num_pages - 1)) ? '0 : p + 1'b1;
  endfunction

  assign init_last = (init_cnt == AW'(g_num_pages - 1));
  assign head      = fifo_mem[rd_ptr];
  assign cur_use   = use_mem[req_q.page];
  assign cur_alloc = alloc_mem[req_q.page];

  assign free_pages_o = count;
  assign nomem_o      = (state == S_INIT) || (count == '0);

  // Fixed priority; an alloc is only eligible when a page is available.
  always_comb begin
    sel_valid      = 1'b0;
    req_nxt        = req_q;
    req_nxt.usecnt = usecnt_i;
    if (free_i) begin
      sel_valid    = 1'b1;
      req_nxt.op   = OP_FREE;
      req_nxt.page = pgaddr_free_i;
    end else if (force_free_i) begin
      sel_valid    = 1'b1;
      req_nxt.op   = OP_FFREE;
      req_nxt.page = pgaddr_force_free_i;
    end else if (set_usecnt_i) begin
      sel_valid    = 1'b1;
      req_nxt.op   = OP_SETUC;
      req_nxt.page = pgaddr_usecnt_i;
    end else if (alloc_i && count != '0) begin
      sel_valid    = 1'b1;
      req_nxt.op   = OP_ALLOC;
      req_nxt.page = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_last) state_nxt = S_IDLE;
      S_IDLE:  if (sel_valid) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operation decode: memory write enables and pool movements for this cycle.
  always_comb begin
    do_pop     = 1'b0;
    do_push    = 1'b0;
    release_pg = 1'b0;
    op_err     = 1'b0;
    op_last    = 1'b0;
    use_we     = 1'b0;
    use_wa     = req_q.page;
    use_wd     = req_q.usecnt;
    al_we      = 1'b0;
    al_wa      = req_q.page;
    al_wd      = 1'b0;
    fifo_we    = 1'b0;
    fifo_wa    = wr_ptr;
    fifo_wd    = req_q.page;
    case (state)
      S_INIT: begin
        use_we  = 1'b1;
        use_wa  = init_cnt;
        use_wd  = '0;
        al_we   = 1'b1;
        al_wa   = init_cnt;
        fifo_we = 1'b1;
        fifo_wa = init_cnt;
        fifo_wd = init_cnt;
      end
      S_EXEC: begin
        case (req_q.op)
          OP_ALLOC: begin
            do_pop = 1'b1;
            use_we = 1'b1;
            use_wa = head;
            al_we  = 1'b1;
            al_wa  = head;
            al_wd  = 1'b1;
          end
          OP_FREE: begin
            if (!cur_alloc || cur_use == '0) begin
              op_err = 1'b1;
            end else if (cur_use == UW'(1)) begin
              release_pg = 1'b1;
              op_last    = 1'b1;
            end else begin
              use_we = 1'b1;
              use_wd = cur_use - UW'(1);
            end
          end
          OP_FFREE: begin
            if (cur_alloc) release_pg = 1'b1;
            else           op_err     = 1'b1;
          end
          default: use_we = 1'b1;
        endcase
      end
      default: ;
    endcase
    if (release_pg) begin
      use_we  = 1'b1;
      use_wd  = '0;
      al_we   = 1'b1;
      al_wd   = 1'b0;
      fifo_we = 1'b1;
      do_push = 1'b1;
    end
  end

  // Storage is plain RAM, rebuilt by the INIT sweep rather than by reset.
  always_ff @(posedge clk_i) begin
    if (use_we)  use_mem[use_wa]   <= use_wd;
    if (al_we)   alloc_mem[al_wa]  <= al_wd;
    if (fifo_we) fifo_mem[fifo_wa] <= fifo_wd;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= S_INIT;
      req_q              <= '0;
      init_cnt           <= '0;
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      count              <= '0;
      pgaddr_alloc_o     <= '0;
      done_o             <= 1'b0;
      alloc_done_o       <= 1'b0;
      free_done_o        <= 1'b0;
      force_free_done_o  <= 1'b0;
      set_usecnt_done_o  <= 1'b0;
      free_last_usecnt_o <= 1'b0;
      err_o              <= 1'b0;
    end else begin
      state              <= state_nxt;
      done_o             <= 1'b0;
      alloc_done_o       <= 1'b0;
      free_done_o        <= 1'b0;
      force_free_done_o  <= 1'b0;
      set_usecnt_done_o  <= 1'b0;
      free_last_usecnt_o <= 1'b0;
      err_o              <= 1'b0;
      case (state)
        S_INIT: begin
          init_cnt <= ptr_inc(init_cnt);
          if (init_last) begin
            count  <= CW'(g_num_pages);
            rd_ptr <= '0;
            wr_ptr <= '0;
          end
        end
        S_IDLE: if (sel_valid) req_q <= req_nxt;
        S_EXEC: begin
          done_o             <= 1'b1;
          alloc_done_o       <= (req_q.op == OP_ALLOC);
          free_done_o        <= (req_q.op == OP_FREE);
          force_free_done_o  <= (req_q.op == OP_FFREE);
          set_usecnt_done_o  <= (req_q.op == OP_SETUC);
          free_last_usecnt_o <= op_last;
          err_o              <= op_err;
          if (do_pop) begin
            rd_ptr         <= ptr_inc(rd_ptr);
            count          <= count - 1'b1;
            pgaddr_alloc_o <= head;
          end else if (do_push) begin
            wr_ptr <= ptr_inc(wr_ptr);
            count  <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swc_page_alloc_core.sv
// Directed and randomized checks of swc_page_alloc_core through its request port.
module tb_swc_page_alloc_core;
  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int UW = 4;
  localparam int K_ALLOC = 0, K_FREE = 1, K_FF = 2, K_SET = 3;

  logic clk = 1'b0;
  logic rst;
  logic alloc_i, free_i, force_free_i, set_usecnt_i;
  logic [UW-1:0] usecnt_i;
  logic [AW-1:0] pgaddr_free_i, pgaddr_force_free_i, pgaddr_usecnt_i;
  logic [AW-1:0] pgaddr_alloc_o;
  logic done_o, alloc_done_o, free_done_o, force_free_done_o, set_usecnt_done_o;
  logic free_last_usecnt_o, nomem_o, err_o;
  logic [AW:0] free_pages_o;

  always #5 clk = ~clk;

  swc_page_alloc_core #(.g_num_pages(N), .g_page_addr_width(AW), .g_usecnt_width(UW)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_i(alloc_i), .free_i(free_i), .force_free_i(force_free_i), .set_usecnt_i(set_usecnt_i),
    .usecnt_i(usecnt_i), .pgaddr_free_i(pgaddr_free_i), .pgaddr_force_free_i(pgaddr_force_free_i),
    .pgaddr_usecnt_i(pgaddr_usecnt_i), .pgaddr_alloc_o(pgaddr_alloc_o), .done_o(done_o),
    .alloc_done_o(alloc_done_o), .free_done_o(free_done_o), .force_free_done_o(force_free_done_o),
    .set_usecnt_done_o(set_usecnt_done_o), .free_last_usecnt_o(free_last_usecnt_o),
    .nomem_o(nomem_o), .err_o(err_o), .free_pages_o(free_pages_o));

  int checks = 0;
  int errors = 0;

  // Outputs captured at the done pulse; r_types is {alloc, free, force_free, set_usecnt}.
  bit          r_got;
  int          r_lat;
  logic [AW-1:0] r_pa;
  logic        r_last, r_err;
  logic [3:0]  r_types;
  logic [AW:0] r_fp;

  // Reference model for the random phase.
  bit m_alloc[N];
  int m_use[N];
  int m_fifo[$];
  int m_live[$];

  function automatic logic [3:0] onehot(input int k);
    logic [3:0] v;
    v = 4'b1000;
    return v >> k;
  endfunction

  task automatic set_req(input int k, input int page, input int uc);
    case (k)
      K_ALLOC: begin alloc_i = 1'b1; usecnt_i = UW'(uc); end
      K_FREE:  begin free_i = 1'b1; pgaddr_free_i = AW'(page); end
      K_FF:    begin force_free_i = 1'b1; pgaddr_force_free_i = AW'(page); end
      default: begin set_usecnt_i = 1'b1; pgaddr_usecnt_i = AW'(page); usecnt_i = UW'(uc); end
    endcase
  endtask

  task automatic clr_types(input logic [3:0] t);
    if (t[3]) alloc_i = 1'b0;
    if (t[2]) free_i = 1'b0;
    if (t[1]) force_free_i = 1'b0;
    if (t[0]) set_usecnt_i = 1'b0;
  endtask

  // Waits up to 'bound' cycles for done; drops the finished request after the done edge.
  task automatic wait_done(input int bound);
    r_got = 1'b0;
    r_lat = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      r_lat++;
      if (done_o) begin
        r_got   = 1'b1;
        r_pa    = pgaddr_alloc_o;
        r_last  = free_last_usecnt_o;
        r_err   = err_o;
        r_types = {alloc_done_o, free_done_o, force_free_done_o, set_usecnt_done_o};
        r_fp    = free_pages_o;
        break;
      end
    end
    if (r_got) begin
      @(posedge clk); #1;
      clr_types(r_types);
    end
  endtask

  task automatic op(input int k, input int page, input int uc);
    @(negedge clk);
    set_req(k, page, uc);
    wait_done(20);
    if (!r_got) clr_types(onehot(k));
  endtask

  task automatic wait_init(output int n, output bit saw_done);
    n = 0;
    saw_done = 1'b0;
    while (nomem_o && n < 1100) begin
      @(posedge clk); #1;
      n++;
      if (done_o) saw_done = 1'b1;
    end
  endtask

  task automatic test_reset();
    int  n;
    bit  sd;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (nomem_o !== 1'b1) begin errors++; $display("FAIL rst_nomem: got %0b expected 1", nomem_o); end
    checks++; if (free_pages_o !== 0) begin errors++; $display("FAIL rst_free_pages: got %0d expected 0", free_pages_o); end
    checks++; if ({done_o, err_o, alloc_done_o, free_last_usecnt_o} !== 4'b0) begin
      errors++; $display("FAIL rst_pulses: got %b expected 0000", {done_o, err_o, alloc_done_o, free_last_usecnt_o}); end
    rst = 1'b0;
    wait_init(n, sd);
    checks++; if (n !== 1024) begin errors++; $display("FAIL init_len: got %0d expected 1024", n); end
    checks++; if (free_pages_o !== 1024) begin errors++; $display("FAIL init_free_pages: got %0d expected 1024", free_pages_o); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL init_done: got %0b expected 0", sd); end
  endtask

  task automatic test_alloc_free();
    op(K_ALLOC, 0, 2);
    checks++; if (!r_got || r_lat !== 2) begin errors++; $display("FAIL alloc_latency: got %0d expected 2", r_lat); end
    checks++; if (r_types !== 4'b1000) begin errors++; $display("FAIL alloc_type: got %b expected 1000", r_types); end
    checks++; if (r_pa !== 0) begin errors++; $display("FAIL alloc_page0: got %0d expected 0", r_pa); end
    checks++; if (r_fp !== 1023) begin errors++; $display("FAIL alloc_fp_at_done: got %0d expected 1023", r_fp); end
    op(K_ALLOC, 0, 1);
    checks++; if (r_pa !== 1) begin errors++; $display("FAIL alloc_page1: got %0d expected 1", r_pa); end
    op(K_FREE, 0, 0);
    checks++; if (r_types !== 4'b0100 || r_last !== 1'b0 || r_err !== 1'b0) begin
      errors++; $display("FAIL free_dec: got types %b last %0b err %0b expected 0100 0 0", r_types, r_last, r_err); end
    checks++; if (free_pages_o !== 1022) begin errors++; $display("FAIL free_dec_fp: got %0d expected 1022", free_pages_o); end
    checks++; if (pgaddr_alloc_o !== 1) begin errors++; $display("FAIL alloc_addr_hold: got %0d expected 1", pgaddr_alloc_o); end
    op(K_FREE, 0, 0);
    checks++; if (r_last !== 1'b1 || r_err !== 1'b0) begin errors++; $display("FAIL free_last: got last %0b err %0b expected 1 0", r_last, r_err); end
    checks++; if (free_pages_o !== 1023) begin errors++; $display("FAIL free_last_fp: got %0d expected 1023", free_pages_o); end
  endtask

  task automatic test_deferred();
    op(K_ALLOC, 0, 0);
    checks++; if (r_pa !== 2) begin errors++; $display("FAIL def_alloc_page: got %0d expected 2", r_pa); end
    op(K_SET, 2, 3);
    checks++; if (r_types !== 4'b0001 || r_err !== 1'b0) begin errors++; $display("FAIL set_type: got %b err %0b expected 0001 0", r_types, r_err); end
    op(K_FREE, 2, 0);
    checks++; if (r_last !== 1'b0 || r_err !== 1'b0) begin errors++; $display("FAIL def_free: got last %0b err %0b expected 0 0", r_last, r_err); end
    checks++; if (free_pages_o !== 1022) begin errors++; $display("FAIL def_free_fp: got %0d expected 1022", free_pages_o); end
    op(K_FF, 2, 0);
    checks++; if (r_types !== 4'b0010 || r_err !== 1'b0) begin errors++; $display("FAIL ff_type: got %b err %0b expected 0010 0", r_types, r_err); end
    checks++; if (free_pages_o !== 1023) begin errors++; $display("FAIL ff_fp: got %0d expected 1023", free_pages_o); end
    op(K_FREE, 2, 0);
    checks++; if (r_err !== 1'b1 || r_last !== 1'b0) begin errors++; $display("FAIL free_unalloc_err: got err %0b last %0b expected 1 0", r_err, r_last); end
    checks++; if (free_pages_o !== 1023) begin errors++; $display("FAIL free_unalloc_fp: got %0d expected 1023", free_pages_o); end
    op(K_FF, 5, 0);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL ff_unalloc_err: got %0b expected 1", r_err); end
  endtask

  task automatic test_priority();
    logic [3:0] seq [3];
    logic [AW-1:0] apa;
    logic flast;
    @(negedge clk);
    set_req(K_FREE, 1, 0);
    set_req(K_SET, 7, 2);
    set_req(K_ALLOC, 0, 2);
    for (int i = 0; i < 3; i++) begin
      wait_done(20);
      seq[i] = r_got ? r_types : 4'b0;
      if (r_types[2]) flast = r_last;
      if (r_types[3]) apa = r_pa;
    end
    clr_types(4'b1111);
    checks++; if ({seq[0], seq[1], seq[2]} !== 12'b0100_0001_1000) begin
      errors++; $display("FAIL prio_order: got %b %b %b expected 0100 0001 1000", seq[0], seq[1], seq[2]); end
    checks++; if (flast !== 1'b1) begin errors++; $display("FAIL prio_free_last: got %0b expected 1", flast); end
    checks++; if (apa !== 3) begin errors++; $display("FAIL prio_alloc_page: got %0d expected 3", apa); end
    checks++; if (free_pages_o !== 1023) begin errors++; $display("FAIL prio_fp: got %0d expected 1023", free_pages_o); end
  endtask

  task automatic test_reset_mid();
    bit sd = 1'b0;
    bit sd2;
    int n;
    @(negedge clk);
    set_req(K_ALLOC, 0, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    alloc_i = 1'b0;
    repeat (3) begin @(negedge clk); if (done_o) sd = 1'b1; end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %0b expected 0", sd); end
    checks++; if (nomem_o !== 1'b1 || free_pages_o !== 0) begin
      errors++; $display("FAIL rstmid_state: got nomem %0b fp %0d expected 1 0", nomem_o, free_pages_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init(n, sd2);
    checks++; if (n !== 1024 || sd2 !== 1'b0) begin errors++; $display("FAIL rstmid_init: got len %0d done %0b expected 1024 0", n, sd2); end
    checks++; if (free_pages_o !== 1024) begin errors++; $display("FAIL rstmid_fp: got %0d expected 1024", free_pages_o); end
  endtask

  task automatic test_exhaust();
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      op(K_ALLOC, 0, 1);
      if (!r_got || r_pa !== AW'(i)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL exhaust_seq: got %0d bad allocs expected 0", bad); end
    checks++; if (nomem_o !== 1'b1 || free_pages_o !== 0) begin
      errors++; $display("FAIL exhaust_nomem: got nomem %0b fp %0d expected 1 0", nomem_o, free_pages_o); end
    @(negedge clk);
    set_req(K_ALLOC, 0, 1);
    wait_done(10);
    checks++; if (r_got !== 1'b0) begin errors++; $display("FAIL exhaust_blocked: got done %0b expected 0", r_got); end
    @(negedge clk);
    set_req(K_FREE, 17, 0);
    wait_done(20);
    checks++; if (r_types !== 4'b0100 || r_last !== 1'b1) begin
      errors++; $display("FAIL exhaust_free17: got types %b last %0b expected 0100 1", r_types, r_last); end
    wait_done(20);
    clr_types(4'b1111);
    checks++; if (!r_got || r_types !== 4'b1000 || r_pa !== 17) begin
      errors++; $display("FAIL exhaust_pending: got done %0b types %b page %0d expected 1 1000 17", r_got, r_types, r_pa); end
    checks++; if (nomem_o !== 1'b1) begin errors++; $display("FAIL exhaust_nomem_again: got %0b expected 1", nomem_o); end
  endtask

  task automatic model_release(input int p);
    m_alloc[p] = 1'b0;
    m_use[p] = 0;
    m_fifo.push_back(p);
    foreach (m_live[i]) if (m_live[i] == p) begin m_live.delete(i); break; end
  endtask

  task automatic test_random();
    int n, n_done = 0, bad = 0;
    bit sd;
    int k, page, uc, e_pa;
    bit e_err, e_last;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init(n, sd);
    m_fifo = {};
    m_live = {};
    for (int i = 0; i < N; i++) begin m_alloc[i] = 1'b0; m_use[i] = 0; m_fifo.push_back(i); end
    for (int t = 0; t < 2000; t++) begin
      n = $urandom_range(0, 99);
      k = (n < 20) ? K_FF : (n < 45) ? K_ALLOC : (n < 80) ? K_FREE : K_SET;
      if (k == K_ALLOC && m_fifo.size() == 0) k = K_FREE;
      uc = $urandom_range(0, 3);
      if (m_live.size() > 0 && $urandom_range(0, 9) != 0) page = m_live[$urandom_range(0, m_live.size() - 1)];
      else page = $urandom_range(0, N - 1);
      e_err = 1'b0; e_last = 1'b0; e_pa = 0;
      case (k)
        K_ALLOC: begin
          e_pa = m_fifo.pop_front();
          m_alloc[e_pa] = 1'b1; m_use[e_pa] = uc; m_live.push_back(e_pa);
        end
        K_FREE: begin
          if (!m_alloc[page] || m_use[page] == 0) e_err = 1'b1;
          else if (m_use[page] == 1) begin e_last = 1'b1; model_release(page); end
          else m_use[page]--;
        end
        K_FF: if (m_alloc[page]) model_release(page); else e_err = 1'b1;
        default: m_use[page] = uc;
      endcase
      op(k, page, uc);
      if (r_got) n_done++;
      if (!r_got || r_types !== onehot(k) || r_err !== e_err || (k == K_FREE && r_last !== e_last) ||
          (k == K_ALLOC && r_pa !== AW'(e_pa))) bad++;
    end
    checks++; if (n_done !== 2000) begin errors++; $display("FAIL rand_dones: got %0d expected 2000", n_done); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_results: got %0d bad ops expected 0", bad); end
    checks++; if (free_pages_o !== (AW+1)'(N - m_live.size())) begin
      errors++; $display("FAIL rand_free_pages: got %0d expected %0d", free_pages_o, N - m_live.size()); end
  endtask

  initial begin
    rst = 1'b1;
    alloc_i = 1'b0; free_i = 1'b0; force_free_i = 1'b0; set_usecnt_i = 1'b0;
    usecnt_i = '0; pgaddr_free_i = '0; pgaddr_force_free_i = '0; pgaddr_usecnt_i = '0;
    test_reset();
    test_alloc_free();
    test_deferred();
    test_priority();
    test_reset_mid();
    test_exhaust();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
